machin_series: RTL and testbench
================================

MACHIN_SERIES -- requirements
Module: machin_series

Interface
REQ-001 SHALL expose parameter WIDTH, default 15, bits per limb.
REQ-002 SHALL expose parameter L, default 16, limb count (out[L-1] integer limb, L-1 fractional limbs).
REQ-003 SHALL expose parameter BASE, default 10000, limb radix, 2 <= BASE <= 2^WIDTH.
REQ-004 SHALL expose parameter NTERMS, default 2, number of formula terms.
REQ-005 SHALL expose parameter MAXK, default 4096, series-index bound per term.
REQ-006 SHALL expose parameter DW, default 16, denominator width.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  one-cycle request, sampled only in IDLE.
REQ-010 coef  in  NTERMS x 8 signed  term coefficients, sampled with start.
REQ-011 den  in  NTERMS x DW  term denominators x (>=1), sampled with start.
REQ-012 busy  out  1  high from cycle after accepted start until done.
REQ-013 done  out  1  one-cycle pulse when result final.
REQ-014 out  out  L x WIDTH  result, sum of coef[j]*arctan(1/den[j]), base-BASE limbs, MS first.
REQ-015 neg  out  1  result negative (out holds BASE^L complement).
REQ-016 err  out  1  some term reached MAXK without converging, or den==0.
REQ-017 cycles  out  32  start-to-done cycle count (see Configuration).

Function
REQ-018 SHALL use FSM IDLE -> LOAD -> DIV_X -> DIV_X2 -> DIV_ODD -> ACCUM -> CHECK -> (DIV_X2 | NEXT) -> NEXT -> (LOAD | FIN) -> IDLE.
REQ-019 LOAD (1 cycle) SHALL set power = |coef[j]| in integer limb, zeros elsewhere; k=0; sign by coef sign.
REQ-020 DIV_X SHALL divide power by den[j], limb-serial MS->LS, one limb per cycle, L cycles.
REQ-021 DIV_X2 SHALL divide power by den[j] again (L cycles); skipped for k=0.
REQ-022 DIV_ODD SHALL form term = power/(2k+1), L cycles, truncating remainder.
REQ-023 ACCUM SHALL add (even k, positive coef) or subtract term to/from acc, LS->MS with carry/borrow, L cycles.
REQ-024 CHECK (1 cycle) SHALL advance k; goes to NEXT if power zero after last division or k==MAXK (latter sets err).
REQ-025 Per-iteration latency SHALL be exactly 3L+1 cycles (k=0: 3L+1 incl. DIV_X instead of DIV_X2).
REQ-026 Division intermediates SHALL be DW+WIDTH+1 bits; no truncation of remainder*BASE+limb.
REQ-027 Borrow out of MS limb SHALL toggle neg; carry out of MS limb SHALL toggle neg back.
REQ-028 FIN SHALL copy acc to out, pulse done, drop busy, same cycle.
REQ-029 out SHALL hold last result until next accepted start; cleared to 0 in LOAD of term 0.
REQ-030 start while busy SHALL be ignored, no state change.
REQ-031 den[j]==0 SHALL skip term j and set err.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, out=0, busy=0, done=0, neg=0, err=0, cycles=0.
REQ-033 Reset mid-operation SHALL discard partial acc; no done pulse after release.

Configuration
REQ-034 With MACHIN_SERIES_CYCLE_COUNT_EN defined, cycles SHALL count clocks from accepted start to done inclusive, held until next start.
REQ-035 Without MACHIN_SERIES_CYCLE_COUNT_EN, cycles SHALL be constant 0 and no counter synthesised.

Structure
REQ-036 Package machin_pkg SHALL hold the FSM state enum, limb typedef, and default BASE/WIDTH constants.
REQ-037 Sub-module limb_divider SHALL implement the L-cycle limb-serial division (start, divisor, done, zero flag), reused for all three division states.

Verification
REQ-038 L=4, coef={16,-4}, den={5,239}, start -> done, out[3]=3, out[2]=1415, out[1]=9265, |out[0]-3590|<=20, neg=0, err=0.
REQ-039 L=4, NTERMS=1, coef=1, den=10000 -> out={0,1,0,0}, done after 2 iterations, err=0.
REQ-040 coef=4, den=1, MAXK=8 -> done after 8 iterations, err=1.
REQ-041 coef={-1,0}, den={2,1} -> neg=1, out = BASE^L complement of arctan(1/2) truncated.
REQ-042 rst_n low during DIV_ODD -> same-cycle out=0, busy=0; no done; new start after release completes normally.
REQ-043 start pulsed while busy -> ignored; with MACHIN_SERIES_CYCLE_COUNT_EN, cycles equals the sum over iterations of 3L+1 plus LOAD/NEXT/FIN overhead.

Source files
------------

// File: rtl/machin_pkg.sv
// Shared types and defaults for the arctan-series engine (machin_series and limb_divider).
package machin_pkg;

  localparam int DEF_WIDTH = 15;
  localparam int DEF_BASE  = 10000;

  typedef logic [DEF_WIDTH-1:0] limb_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_DIV_X,
    S_DIV_X2,
    S_DIV_ODD,
    S_ACCUM,
    S_CHECK,
    S_NEXT,
    S_FIN
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/limb_divider.sv
// Limb-serial long division, MS limb first, one limb per cycle for L cycles.
// With dbl set, a second cascaded stage divides the quotient stream by the divisor again.
module limb_divider
  import machin_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int L     = 16,
  parameter int BASE  = DEF_BASE,
  parameter int DW    = 16,
  localparam int IW   = idx_width(L)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dbl,
  input  logic [DW-1:0]    divisor,
  input  logic [WIDTH-1:0] limb,
  output logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] quot,
  output logic             done,
  output logic             zero
);

  localparam int NW = DW + WIDTH + 1;

  logic             active;
  logic             dbl_r;
  logic             any_nz;
  logic [IW-1:0]    cnt;
  logic [DW-1:0]    div_r;
  logic [DW-1:0]    div_safe;
  logic [DW-1:0]    r1;
  logic [DW-1:0]    r2;
  logic [DW-1:0]    rem1;
  logic [DW-1:0]    rem2;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [NW-1:0]    num1;
  logic [NW-1:0]    num2;

  // Remainders stay below the divisor, so remainder*BASE+limb never exceeds NW bits.
  always_comb begin
    div_safe = (div_r == '0) ? DW'(1) : div_r;
    num1     = NW'(r1) * NW'(BASE) + NW'(limb);
    q1       = WIDTH'(num1 / NW'(div_safe));
    rem1     = DW'(num1 % NW'(div_safe));
    num2     = NW'(r2) * NW'(BASE) + NW'(q1);
    q2       = WIDTH'(num2 / NW'(div_safe));
    rem2     = DW'(num2 % NW'(div_safe));
    quot     = dbl_r ? q2 : q1;
    idx      = IW'(L - 1) - cnt;
    done     = active && (cnt == IW'(L - 1));
    zero     = !any_nz && (quot == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      dbl_r  <= 1'b0;
      any_nz <= 1'b0;
      cnt    <= '0;
      div_r  <= '0;
      r1     <= '0;
      r2     <= '0;
    end else if (start) begin
      active <= 1'b1;
      dbl_r  <= dbl;
      any_nz <= 1'b0;
      cnt    <= '0;
      div_r  <= divisor;
      r1     <= '0;
      r2     <= '0;
    end else if (active) begin
      r1     <= rem1;
      r2     <= rem2;
      any_nz <= any_nz | (quot != '0);
      cnt    <= done ? '0 : cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/machin_series.sv
// Machin-style series engine: out = sum_j coef[j]*arctan(1/den[j]) in base-BASE limbs.
// Define MACHIN_SERIES_CYCLE_COUNT_EN to enable the start-to-done cycle counter.
module machin_series
  import machin_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int L      = 16,
  parameter int BASE   = DEF_BASE,
  parameter int NTERMS = 2,
  parameter int MAXK   = 4096,
  parameter int DW     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NTERMS-1:0][7:0]    coef,
  input  logic [NTERMS-1:0][DW-1:0] den,
  output logic                      busy,
  output logic                      done,
  output logic [L-1:0][WIDTH-1:0]   out,
  output logic                      neg,
  output logic                      err,
  output logic [31:0]               cycles
);

  localparam int IW = idx_width(L);
  localparam int JW = idx_width(NTERMS);
  localparam int KW = idx_width(MAXK + 1);
  localparam int AW = WIDTH + 2;

  state_t                    state;
  logic [L-1:0][WIDTH-1:0]   power;
  logic [L-1:0][WIDTH-1:0]   term;
  logic [L-1:0][WIDTH-1:0]   acc;
  logic [NTERMS-1:0][7:0]    coef_r;
  logic [NTERMS-1:0][DW-1:0] den_r;
  logic [JW-1:0]             j;
  logic [KW-1:0]             k;
  logic [IW-1:0]             acnt;
  logic                      carry;
  logic                      term_zero;

  logic                      div_go;
  logic                      div_dbl;
  logic                      div_done;
  logic                      div_zero;
  logic [DW-1:0]             div_divisor;
  logic [DW-1:0]             odd;
  logic [IW-1:0]             div_idx;
  logic [WIDTH-1:0]          div_quot;
  logic                      last_iter;
  logic [7:0]                coef_mag;

  logic                      do_sub;
  logic [WIDTH-1:0]          acc_limb;
  logic [WIDTH-1:0]          term_limb;
  logic [WIDTH-1:0]          sum_limb;
  logic [AW-1:0]             tc;
  logic [AW-1:0]             wide;
  logic                      cout;

  // Each division is kicked off in the cycle before its state so every state lasts exactly L cycles.
  always_comb begin
    odd         = DW'({k, 1'b1});
    last_iter   = term_zero || ((k + 1'b1) == KW'(MAXK));
    coef_mag    = coef_r[j][7] ? (8'd0 - coef_r[j]) : coef_r[j];
    div_go      = 1'b0;
    div_dbl     = 1'b0;
    div_divisor = den_r[j];
    case (state)
      S_LOAD:            div_go = (den_r[j] != '0);
      S_DIV_X, S_DIV_X2: begin
        div_go      = div_done;
        div_divisor = odd;
      end
      S_CHECK: begin
        div_go  = !last_iter;
        div_dbl = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    do_sub    = k[0] ^ coef_r[j][7];
    acc_limb  = acc[acnt];
    term_limb = term[acnt];
    tc        = AW'(term_limb) + AW'(carry);
    if (do_sub) begin
      cout = (AW'(acc_limb) < tc);
      wide = cout ? (AW'(acc_limb) + AW'(BASE) - tc) : (AW'(acc_limb) - tc);
    end else begin
      wide = AW'(acc_limb) + tc;
      cout = (wide >= AW'(BASE));
      if (cout) wide = wide - AW'(BASE);
    end
    sum_limb = WIDTH'(wide);
  end

  limb_divider #(
    .WIDTH(WIDTH),
    .L    (L),
    .BASE (BASE),
    .DW   (DW)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (div_go),
    .dbl    (div_dbl),
    .divisor(div_divisor),
    .limb   (power[div_idx]),
    .idx    (div_idx),
    .quot   (div_quot),
    .done   (div_done),
    .zero   (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
      power     <= '0;
      term      <= '0;
      acc       <= '0;
      coef_r    <= '0;
      den_r     <= '0;
      j         <= '0;
      k         <= '0;
      acnt      <= '0;
      carry     <= 1'b0;
      term_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            coef_r <= coef;
            den_r  <= den;
            j      <= '0;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (j == '0) begin
            out <= '0;
            acc <= '0;
            neg <= 1'b0;
            err <= 1'b0;
          end
          k         <= '0;
          carry     <= 1'b0;
          term_zero <= 1'b0;
          if (den_r[j] == '0) begin
            err   <= 1'b1;
            state <= S_NEXT;
          end else begin
            power        <= '0;
            power[L-1]   <= WIDTH'(coef_mag);
            state        <= S_DIV_X;
          end
        end
        S_DIV_X, S_DIV_X2: begin
          power[div_idx] <= div_quot;
          if (div_done) state <= S_DIV_ODD;
        end
        S_DIV_ODD: begin
          term[div_idx] <= div_quot;
          if (div_done) begin
            term_zero <= div_zero;
            acnt      <= '0;
            state     <= S_ACCUM;
          end
        end
        // Carry or borrow out of the MS limb crosses zero in BASE^L complement form.
        S_ACCUM: begin
          acc[acnt] <= sum_limb;
          carry     <= cout;
          acnt      <= acnt + 1'b1;
          if (acnt == IW'(L - 1)) begin
            carry <= 1'b0;
            acnt  <= '0;
            if (cout) neg <= ~neg;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          k <= k + 1'b1;
          if (last_iter) begin
            if (!term_zero) err <= 1'b1;
            state <= S_NEXT;
          end else begin
            state <= S_DIV_X2;
          end
        end
        S_NEXT: begin
          if (j == JW'(NTERMS - 1)) begin
            state <= S_FIN;
          end else begin
            j     <= j + 1'b1;
            state <= S_LOAD;
          end
        end
        S_FIN: begin
          out   <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MACHIN_SERIES_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
    end else if (state == S_IDLE) begin
      if (start) cycles <= 32'd1;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end
`else
  assign cycles = 32'd0;
`endif

endmodule

// File: tb/tb_machin_series.sv
// Self-checking bench for machin_series against an integer fixed-point arctan-series model.
module tb_machin_series;

  localparam int WIDTH  = 15;
  localparam int L      = 4;
  localparam int BASE   = 10000;
  localparam int NTERMS = 2;
  localparam int MAXK   = 16;
  localparam int DW     = 16;

  logic                      clk   = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      start = 1'b0;
  logic [NTERMS-1:0][7:0]    coef;
  logic [NTERMS-1:0][DW-1:0] den;
  logic                      busy;
  logic                      done;
  logic [L-1:0][WIDTH-1:0]   out;
  logic                      neg;
  logic                      err;
  logic [31:0]               cycles;

  int checks = 0;
  int fails  = 0;
  int lat;
  int nd;
  int c0, c1, d0, d1;

  always #5 clk = ~clk;

  machin_series #(
    .WIDTH (WIDTH),
    .L     (L),
    .BASE  (BASE),
    .NTERMS(NTERMS),
    .MAXK  (MAXK),
    .DW    (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .coef  (coef),
    .den   (den),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .neg   (neg),
    .err   (err),
    .cycles(cycles)
  );

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Signed value scaled by BASE^(L-1), plus error flag and start-to-done clock count.
  function automatic void model(input int mc0, input int mc1, input int md0, input int md1,
                                output longint val, output bit e, output int cyc);
    int cs[2];
    int ds[2];
    longint scale, p, t;
    cs = '{mc0, mc1};
    ds = '{md0, md1};
    scale = 1;
    for (int i = 0; i < L - 1; i++) scale *= BASE;
    val = 0;
    e   = 1'b0;
    cyc = 2;
    for (int n = 0; n < NTERMS; n++) begin
      cyc += 2;
      if (ds[n] == 0) begin
        e = 1'b1;
        continue;
      end
      p = longint'(cs[n] < 0 ? -cs[n] : cs[n]) * scale / ds[n];
      for (int kk = 0; kk < MAXK; kk++) begin
        cyc += 3 * L + 1;
        t = p / (2 * kk + 1);
        if (((kk % 2) == 1) != (cs[n] < 0)) val -= t;
        else val += t;
        if (t == 0) break;
        if (kk + 1 == MAXK) begin
          e = 1'b1;
          break;
        end
        p = p / (longint'(ds[n]) * ds[n]);
      end
    end
  endfunction

  task automatic applyStimulus(input int ac0, input int ac1, input int ad0, input int ad1,
                               input int spur, output int lat_o);
    coef[0] = 8'(ac0);
    coef[1] = 8'(ac1);
    den[0]  = DW'(ad0);
    den[1]  = DW'(ad1);
    start   = 1'b1;
    lat_o   = 0;
    while (lat_o < 2000) begin
      @(negedge clk);
      lat_o++;
      start = 1'b0;
      if (lat_o == 1) chk("busy_after_start", busy, 1);
      if (spur != 0 && lat_o == spur) begin
        start   = 1'b1;
        coef[0] = 8'($urandom_range(0, 255));
        den[0]  = DW'($urandom_range(1, 50));
      end
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic checkOutput(input string tag, input int oc0, input int oc1, input int od0,
                             input int od1, input int lat_o);
    longint v, u, pw, bl;
    bit     e;
    int     cyc;
    model(oc0, oc1, od0, od1, v, e, cyc);
    bl = 1;
    for (int i = 0; i < L; i++) bl *= BASE;
    u  = (v < 0) ? bl + v : v;
    pw = 1;
    for (int i = 0; i < L; i++) begin
      chk($sformatf("%s_out%0d", tag, i), out[i], (u / pw) % BASE);
      pw *= BASE;
    end
    chk({tag, "_neg"}, neg, (v < 0) ? 1 : 0);
    chk({tag, "_err"}, err, e);
    chk({tag, "_latency"}, lat_o, cyc);
    chk({tag, "_busy_low"}, busy, 0);
`ifdef MACHIN_SERIES_CYCLE_COUNT_EN
    chk({tag, "_cycles"}, cycles, cyc);
`else
    chk({tag, "_cycles"}, cycles, 0);
`endif
  endtask

  initial begin
    coef = '0;
    den  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_neg", neg, 0);
    chk("reset_err", err, 0);
    chk("reset_cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] Machin formula for pi");
    applyStimulus(16, -4, 5, 239, 0, lat);
    checkOutput("machin", 16, -4, 5, 239, lat);
    chk("pi_int", out[3], 3);
    chk("pi_f1", out[2], 1415);
    chk("pi_f2", out[1], 9265);
    chk("pi_f3_close", (out[0] >= 3570 && out[0] <= 3610) ? 1 : 0, 1);

    $display("[TB] arctan(1/10000)");
    applyStimulus(1, 0, 10000, 1, 0, lat);
    checkOutput("atan1e4", 1, 0, 10000, 1, lat);
    chk("atan1e4_limbs", out, 64'h0000_0001_0000_0000 & 64'hFFFF_FFFF_FFFF_FFFF ? {15'd0, 15'd1, 15'd0, 15'd0} : 0);
    chk("atan1e4_latency_fixed", lat, 45);

    $display("[TB] non-converging series hits MAXK");
    applyStimulus(4, 0, 1, 1, 0, lat);
    checkOutput("maxk", 4, 0, 1, 1, lat);
    chk("maxk_err", err, 1);
    chk("maxk_latency_fixed", lat, 227);

    $display("[TB] negative result");
    applyStimulus(-1, 0, 2, 1, 0, lat);
    checkOutput("negres", -1, 0, 2, 1, lat);
    chk("negres_neg", neg, 1);

    $display("[TB] zero denominator");
    applyStimulus(16, -4, 0, 239, 0, lat);
    checkOutput("den0", 16, -4, 0, 239, lat);

    $display("[TB] start while busy");
    applyStimulus(16, -4, 5, 239, 10, lat);
    checkOutput("busystart", 16, -4, 5, 239, lat);

    $display("[TB] reset during DIV_ODD");
    coef[0] = 8'(16);
    coef[1] = 8'(-4);
    den[0]  = DW'(5);
    den[1]  = DW'(239);
    start   = 1'b1;
    repeat (7) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_out", out, 0);
    chk("midreset_done", done, 0);
    chk("midreset_cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_reset", nd, 0);
    applyStimulus(16, -4, 5, 239, 0, lat);
    checkOutput("after_reset", 16, -4, 5, 239, lat);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      c0 = int'($urandom_range(0, 60)) - 30;
      c1 = int'($urandom_range(0, 60)) - 30;
      d0 = int'($urandom_range(2, 400));
      d1 = int'($urandom_range(2, 400));
      applyStimulus(c0, c1, d0, d1, 0, lat);
      checkOutput($sformatf("rand%0d", r), c0, c1, d0, d1, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
